// File: rtl/membrane_integrator_if.sv
// Handshake/data bundle between a neuron controller and the membrane integrator.
// The controller owns the window controls and current stream; the integrator owns potential and status.
interface membrane_integrator_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned STEP_WIDTH = 8
);
  logic                          start;
  logic [STEP_WIDTH-1:0]         num_timesteps;
  logic signed [DATA_WIDTH-1:0]  threshold;
  logic signed [DATA_WIDTH-1:0]  current_in;
  logic                          current_valid;
  logic signed [DATA_WIDTH-1:0]  membrane_potential;
  logic                          spike;
  logic                          busy;
  logic                          done;

  modport master (
    output start, num_timesteps, threshold, current_in, current_valid,
    input  membrane_potential, spike, busy, done
  );

  modport slave (
    input  start, num_timesteps, threshold, current_in, current_valid,
    output membrane_potential, spike, busy, done
  );
endinterface

// File: rtl/membrane_integrator.sv
// Leaky integrate-and-fire membrane for one neuron over a window of timesteps.
// Each timestep is an INTEGRATE (leak + current) followed by a FIRE (threshold test, reset by subtraction).
module membrane_integrator #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LEAK_SHIFT = 4,
  parameter int unsigned STEP_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rstn,
  membrane_integrator_if.slave bus
);

  localparam int unsigned SUM_W = DATA_WIDTH + 2;
  localparam logic signed [SUM_W-1:0] V_MAX = {3'b000, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] V_MIN = {3'b111, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    INTEGRATE,
    FIRE,
    DONE
  } state_t;

  state_t                       state, state_nxt;
  logic signed [DATA_WIDTH-1:0] v, v_nxt;
  logic signed [DATA_WIDTH-1:0] thr_q, thr_nxt;
  logic [STEP_WIDTH-1:0]        nts_q, nts_nxt;
  logic [STEP_WIDTH-1:0]        step_cnt, step_nxt;
  logic                         busy_q, done_q;
  logic                         spike_c;

  logic signed [DATA_WIDTH-1:0] leak;
  logic signed [SUM_W-1:0]      v_ext, leak_ext, cur_ext, thr_ext;
  logic signed [SUM_W-1:0]      int_sum, fire_diff;

  function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [SUM_W-1:0] x);
    if (x > V_MAX) begin
      return V_MAX[DATA_WIDTH-1:0];
    end else if (x < V_MIN) begin
      return V_MIN[DATA_WIDTH-1:0];
    end else begin
      return x[DATA_WIDTH-1:0];
    end
  endfunction

  // Widened datapath so leak+current and reset-by-subtraction never wrap before clamping
  always_comb begin
    leak      = v >>> LEAK_SHIFT;
    v_ext     = {{2{v[DATA_WIDTH-1]}}, v};
    leak_ext  = {{2{leak[DATA_WIDTH-1]}}, leak};
    cur_ext   = {{2{bus.current_in[DATA_WIDTH-1]}}, bus.current_in};
    thr_ext   = {{2{thr_q[DATA_WIDTH-1]}}, thr_q};
    int_sum   = v_ext - leak_ext + cur_ext;
    fire_diff = v_ext - thr_ext;
  end

  always_comb begin
    state_nxt = state;
    v_nxt     = v;
    thr_nxt   = thr_q;
    nts_nxt   = nts_q;
    step_nxt  = step_cnt;
    spike_c   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          v_nxt     = '0;
          step_nxt  = '0;
          thr_nxt   = bus.threshold;
          nts_nxt   = (bus.num_timesteps == '0) ? STEP_WIDTH'(1) : bus.num_timesteps;
          state_nxt = INTEGRATE;
        end
      end
      INTEGRATE: begin
        if (bus.current_valid) begin
          v_nxt     = sat(int_sum);
          state_nxt = FIRE;
        end
      end
      FIRE: begin
        if (v >= thr_q) begin
          spike_c = 1'b1;
          v_nxt   = sat(fire_diff);
        end
        step_nxt  = step_cnt + STEP_WIDTH'(1);
        state_nxt = (step_cnt == nts_q - STEP_WIDTH'(1)) ? DONE : INTEGRATE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state    <= IDLE;
      v        <= '0;
      thr_q    <= '0;
      nts_q    <= STEP_WIDTH'(1);
      step_cnt <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      v        <= v_nxt;
      thr_q    <= thr_nxt;
      nts_q    <= nts_nxt;
      step_cnt <= step_nxt;
      busy_q   <= (state_nxt == INTEGRATE) || (state_nxt == FIRE);
      done_q   <= (state_nxt == DONE);
    end
  end

  assign bus.membrane_potential = v;
  assign bus.spike              = spike_c;
  assign bus.busy               = busy_q;
  assign bus.done               = done_q;

endmodule

// File: doc/membrane_integrator.md
MEMBRANE_INTEGRATOR -- requirements
Module: membrane_integrator

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and rstn; rstn=1 at a rising clk edge resets the block.
REQ-002 Parameter DATA_WIDTH, default 16: width of currents, threshold and membrane potential (signed two's complement).
REQ-003 Parameter LEAK_SHIFT, default 4: leak per timestep is v >>> LEAK_SHIFT (arithmetic).
REQ-004 Parameter STEP_WIDTH, default 8: width of the timestep count.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rstn  in  1  synchronous active-high reset.
REQ-007 start  in  1  pulse; begins an inference window; accepted only in IDLE.
REQ-008 num_timesteps  in  STEP_WIDTH  timesteps in the window, unsigned; sampled on accepted start.
REQ-009 threshold  in  DATA_WIDTH signed  firing threshold; sampled on accepted start.
REQ-010 current_in  in  DATA_WIDTH signed  weighted input current for the current timestep.
REQ-011 current_valid  in  1  current_in is valid; consumed only in INTEGRATE.
REQ-012 membrane_potential  out  DATA_WIDTH signed  registered potential v.
REQ-013 spike  out  1  one-cycle pulse when v crosses threshold.
REQ-014 busy  out  1  high in INTEGRATE and FIRE.
REQ-015 done  out  1  one-cycle pulse at end of window.

Function
REQ-016 FSM states SHALL be IDLE, INTEGRATE, FIRE and DONE, with one register update per cycle.
REQ-017 IDLE with start=1: v<=0, step_cnt<=0, latch threshold and num_timesteps (0 latched as 1), next state INTEGRATE. start in any other state is ignored.
REQ-018 INTEGRATE with current_valid=1: v <= sat(v - (v>>>LEAK_SHIFT) + current_in), next state FIRE.
REQ-019 INTEGRATE with current_valid=0: hold v and stay in INTEGRATE (stall, no leak applied).
REQ-020 The sum SHALL be computed at DATA_WIDTH+2 bits and saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-021 FIRE: if v >= latched threshold (signed compare), spike=1 for this cycle and v <= sat(v - threshold) (reset by subtraction); otherwise spike=0 and v holds.
REQ-022 FIRE: step_cnt increments; if step_cnt equals latched num_timesteps-1, next state DONE, else INTEGRATE.
REQ-023 DONE: done=1 for exactly one cycle, v holds, next state IDLE; start during DONE is ignored.
REQ-024 spike SHALL be combinationally asserted only in FIRE; it is never asserted in any other state.
REQ-025 membrane_potential SHALL always reflect the v register; v holds in IDLE after a window.
REQ-026 The minimum window latency from the start edge to done is 2*num_timesteps+1 cycles with current_valid held at 1.

Reset
REQ-027 On rstn=1 the block SHALL enter IDLE with v=0, step_cnt=0, latched threshold=0 and latched num_timesteps=1; spike, busy and done are 0 from the next edge.
REQ-028 Reset asserted mid-window (any state) SHALL abort the window immediately with no done pulse; rstn has priority over start.

Verification
REQ-029 DATA_WIDTH=16, LEAK_SHIFT=4, threshold=100, num_timesteps=3, current 60/60/60 with current_valid=1 -> v=60 (no spike), then 117 with spike and v->17, then 76 (no spike); done pulses once at cycle 7 after start.
REQ-030 Stall: current_valid=0 for 5 cycles during INTEGRATE -> v, step_cnt and busy hold, no spike; the window resumes correctly when current_valid returns to 1.
REQ-031 Saturation: current_in=32767 for 2 steps with threshold=32767 -> v stays clamped at 32767; spike then v=0; a current_in=-32768 sequence from v=-32768 -> v clamps at -32768 with no wrap.
REQ-032 Negative leak: with v=-5 and current_in=0 -> v=-4 after INTEGRATE (-5>>>4 = -1).
REQ-033 Reset mid-window: rstn=1 during INTEGRATE of step 2 -> next edge v=0, busy=0, no done; a subsequent start runs a full clean window.
REQ-034 num_timesteps=0 and start during busy -> exactly one timestep is executed, the extra start is ignored, and exactly one done pulse occurs.
